// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dp_pkg
// Brief    : Shared datapath types and constants for the fetch/execute front end.
// Revision : 1.0 - initial release
// ============================================================================
package dp_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fsm_state_t;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_POP   = 6'd19;
    localparam logic [5:0] OP_BALN  = 6'd27;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_CMPLI = 6'd38;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BLTI  = 6'd44;

    localparam logic [4:0] LINK_REG = 5'd31;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_if
// Brief    : Instruction-memory request/acknowledge bus.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/next_pc_logic.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_logic
// Brief    : Combinational sequential/branch/jump target selection.
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_logic #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [25:0]       instr_idx,
    input  logic              jump,
    input  logic              branch,
    input  logic              branch_on_n,
    input  logic              is_blti,
    input  logic              n_flag,
    input  logic              alu_neg,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] p4,
    output logic [ADDR_W-1:0] next_pc,
    output logic              jump_taken
);
    logic [ADDR_W-1:0] btarget;
    logic [ADDR_W-1:0] jtarget;
    logic              branch_taken;

    always_comb begin
        p4           = pc + ADDR_W'(4);
        btarget      = p4 + {{(ADDR_W-18){instr_idx[15]}}, instr_idx[15:0], 2'b00};
        jtarget      = {p4[ADDR_W-1:28], instr_idx, 2'b00};
        // baln tests the committed flag, not this instruction's own result
        jump_taken   = jump & (branch_on_n ? n_flag : 1'b1);
        branch_taken = branch & (is_blti ? alu_neg : alu_zero);
        if (jump_taken) begin
            next_pc = jtarget;
        end else if (branch_taken) begin
            next_pc = btarget;
        end else begin
            next_pc = p4;
        end
    end
endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC holder, variable-latency fetch FSM and N/Z flag register.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import dp_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master imem,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    input  logic              branch,
    input  logic              jump,
    input  logic              link,
    input  logic              branch_on_n,
    input  logic              is_blti,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              flags_we,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              link_we,
    output logic              n_flag,
    output logic              z_flag
);
    localparam logic [ADDR_W-1:0] C_RESET_PC = {RESET_PC[ADDR_W-1:2], 2'b00};

    logic [1:0]        state_q,       state_d;
    logic [ADDR_W-1:0] pc_q,          pc_d;
    logic [31:0]       instr_q,       instr_d;
    logic              imem_req_q,    imem_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic              link_we_q,     link_we_d;
    logic              n_flag_q,      n_flag_d;
    logic              z_flag_q,      z_flag_d;

    logic [ADDR_W-1:0] w_p4;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_jump_taken;

    next_pc_logic #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc          (pc_q),
        .instr_idx   (instr_q[25:0]),
        .jump        (jump),
        .branch      (branch),
        .branch_on_n (branch_on_n),
        .is_blti     (is_blti),
        .n_flag      (n_flag_q),
        .alu_neg     (alu_neg),
        .alu_zero    (alu_zero),
        .p4          (w_p4),
        .next_pc     (w_next_pc),
        .jump_taken  (w_jump_taken)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        n_flag_d  = n_flag_q;
        z_flag_d  = z_flag_q;
        link_we_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    pc_d      = w_next_pc;
                    link_we_d = link & w_jump_taken;
                    if (flags_we) begin
                        n_flag_d = alu_neg;
                        z_flag_d = alu_zero;
                    end
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        // Request and valid are registered copies of the upcoming state
        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_EXEC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= C_RESET_PC;
            instr_q       <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            link_we_q     <= 1'b0;
            n_flag_q      <= 1'b0;
            z_flag_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            link_we_q     <= link_we_d;
            n_flag_q      <= n_flag_d;
            z_flag_q      <= z_flag_d;
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign opcode         = instr_q[31:26];
    assign instr_valid    = instr_valid_q;
    assign pc             = pc_q;
    assign link_addr      = w_p4;
    assign link_we        = link_we_q;
    assign n_flag         = n_flag_q;
    assign z_flag         = z_flag_q;
endmodule
`default_nettype wire
